// File: rtl/asym_fifo_pack.sv
// Narrow-in / wide-out packing FIFO: DATA_WIDTH writes, 2*DATA_WIDTH reads of two consecutive entries.
// Optional sticky overflow/underflow flags are built when ASYM_FIFO_PACK_ERR_EN is defined.
module asym_fifo_pack #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr,
    input  logic                    rd,
    input  logic [DATA_WIDTH-1:0]   w_data,
    output logic [2*DATA_WIDTH-1:0] r_data,
    output logic                    full,
    output logic                    empty,
    output logic [ADDR_WIDTH:0]     level
`ifdef ASYM_FIFO_PACK_ERR_EN
    ,
    output logic                    overflow,
    output logic                    underflow
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] TWO_C   = (ADDR_WIDTH + 1)'(2);
    localparam logic [ADDR_WIDTH:0] ZERO_C  = (ADDR_WIDTH + 1)'(0);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [ADDR_WIDTH-1:0] w_ptr_r;
    logic [ADDR_WIDTH-1:0] r_ptr_r;
    logic [ADDR_WIDTH-1:0] r_ptr_hi_s;
    logic [ADDR_WIDTH:0]   count_r;
    logic [ADDR_WIDTH:0]   count_next_s;
    logic                  full_s;
    logic                  empty_s;
    logic                  wr_ok_s;
    logic                  rd_ok_s;

    // Flags, acceptance and next occupancy, all derived from the current count.
    always_comb begin
        full_s       = (count_r == DEPTH_C);
        empty_s      = (count_r < TWO_C);
        wr_ok_s      = wr & ~full_s & ~reset;
        rd_ok_s      = rd & ~empty_s & ~reset;
        r_ptr_hi_s   = r_ptr_r + ADDR_WIDTH'(1);
        count_next_s = count_r + (ADDR_WIDTH + 1)'(wr_ok_s);
        if (rd_ok_s) begin
            count_next_s = count_next_s - TWO_C;
        end else begin
            count_next_s = count_next_s - ZERO_C;
        end
    end

    // Head pair read-out; r_ptr is always even so the pair never straddles the wrap.
    always_comb begin
        full  = full_s;
        empty = empty_s;
        level = count_r;
        if (empty_s) begin
            r_data = {(2 * DATA_WIDTH){1'b0}};
        end else begin
            r_data = {mem_r[r_ptr_hi_s], mem_r[r_ptr_r]};
        end
    end

    // Storage array; intentionally left unreset.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[w_ptr_r] <= w_data;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_ptr_r <= {ADDR_WIDTH{1'b0}};
            r_ptr_r <= {ADDR_WIDTH{1'b0}};
            count_r <= {(ADDR_WIDTH + 1){1'b0}};
        end else begin
            if (wr_ok_s) begin
                w_ptr_r <= w_ptr_r + ADDR_WIDTH'(1);
            end
            if (rd_ok_s) begin
                r_ptr_r <= r_ptr_r + ADDR_WIDTH'(2);
            end
            count_r <= count_next_s;
        end
    end

`ifdef ASYM_FIFO_PACK_ERR_EN
    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr & full_s) begin
                overflow <= 1'b1;
            end
            if (rd & empty_s) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_asym_fifo_pack.sv
// Self-checking bench for asym_fifo_pack: narrow-entry queue model as scoreboard, directed steps.
module tb_asym_fifo_pack;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            wr;
    logic            rd;
    logic [DW-1:0]   w_data;
    wire  [2*DW-1:0] r_data;
    wire             full;
    wire             empty;
    wire  [AW:0]     level;
`ifdef ASYM_FIFO_PACK_ERR_EN
    wire             overflow;
    wire             underflow;
`endif

    logic [DW-1:0] q[$];
    int            tests = 0;
    int            fails = 0;
    logic          ovf_exp = 1'b0;
    logic          unf_exp = 1'b0;

    always #5 clk = ~clk;

    asym_fifo_pack #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk),
        .reset(reset),
        .wr(wr),
        .rd(rd),
        .w_data(w_data),
        .r_data(r_data),
        .full(full),
        .empty(empty),
        .level(level)
`ifdef ASYM_FIFO_PACK_ERR_EN
        ,
        .overflow(overflow),
        .underflow(underflow)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*DW-1:0] model_rdata();
        if (q.size() >= 2) return {q[1], q[0]};
        else return '0;
    endfunction

    task automatic check_state(input string tag);
        check({tag, " level"}, 32'(level), 32'(q.size()));
        check({tag, " empty"}, 32'(empty), 32'(q.size() < 2));
        check({tag, " full"}, 32'(full), 32'(q.size() == DEPTH));
        check({tag, " r_data"}, 32'(r_data), 32'(model_rdata()));
`ifdef ASYM_FIFO_PACK_ERR_EN
        check({tag, " overflow"}, 32'(overflow), 32'(ovf_exp));
        check({tag, " underflow"}, 32'(underflow), 32'(unf_exp));
`endif
    endtask

    // One clock of stimulus; accepted reads are compared against the scoreboard head pair.
    task automatic step(input string tag, input logic w, input logic r, input logic [DW-1:0] d);
        logic full_m;
        logic empty_m;
        logic [2*DW-1:0] exp_pair;
        @(negedge clk);
        wr = w; rd = r; w_data = d;
        full_m  = (q.size() == DEPTH);
        empty_m = (q.size() < 2);
        if (w && full_m) ovf_exp = 1'b1;
        if (r && empty_m) unf_exp = 1'b1;
        if (r && !empty_m) begin
            exp_pair = {q[1], q[0]};
            check({tag, " rd pair"}, 32'(r_data), 32'(exp_pair));
            void'(q.pop_front());
            void'(q.pop_front());
        end
        if (w && !full_m) q.push_back(d);
        @(posedge clk);
        #1;
        wr = 1'b0; rd = 1'b0;
        check_state(tag);
    endtask

    task automatic do_reset(input string tag, input logic w, input logic r);
        @(negedge clk);
        reset = 1'b1; wr = w; rd = r; w_data = 8'hEE;
        @(posedge clk);
        #1;
        wr = 1'b0; rd = 1'b0;
        q.delete();
        ovf_exp = 1'b0;
        unf_exp = 1'b0;
        check_state(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [DW-1:0]   fill_tab [8];
        logic [2*DW-1:0] rd_tab [4];
        fill_tab = '{8'h05, 8'h08, 8'h02, 8'h00, 8'h09, 8'h03, 8'h06, 8'h01};
        rd_tab   = '{16'h0805, 16'h0002, 16'h0309, 16'h0106};
        reset = 1'b1; wr = 1'b0; rd = 1'b0; w_data = '0;

        // 1: reset state
        do_reset("reset", 1'b0, 1'b0);
        check("reset r_data const", 32'(r_data), 32'h0);

        // 2: lone entry stays invisible until its partner arrives
        step("s2 w05", 1'b1, 1'b0, 8'h05);
        check("s2 lone empty", 32'(empty), 32'h1);
        step("s2 w08", 1'b1, 1'b0, 8'h08);
        check("s2 pair const", 32'(r_data), 32'h0805);

        // 3: fill, dropped write, drain
        do_reset("s3 reset", 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step("s3 fill", 1'b1, 1'b0, fill_tab[i]);
        check("s3 full const", 32'(full), 32'h1);
        step("s3 drop", 1'b1, 1'b0, 8'h03);
        check("s3 drop level", 32'(level), 32'h8);
        for (int i = 0; i < 4; i++) begin
            check("s3 rd const", 32'(r_data), 32'(rd_tab[i]));
            step("s3 drain", 1'b0, 1'b1, 8'h00);
        end
        check("s3 end empty", 32'(empty), 32'h1);

        // 4: read while empty is ignored, no pointer skew
        step("s4 rd empty", 1'b0, 1'b1, 8'h00);
        step("s4 w04", 1'b1, 1'b0, 8'h04);
        step("s4 w05", 1'b1, 1'b0, 8'h05);
        check("s4 skew const", 32'(r_data), 32'h0504);

        // 5: simultaneous read and write
        do_reset("s5 reset", 1'b0, 1'b0);
        step("s5 w04", 1'b1, 1'b0, 8'h04);
        step("s5 w05", 1'b1, 1'b0, 8'h05);
        step("s5 w06", 1'b1, 1'b0, 8'h06);
        step("s5 rdwr", 1'b1, 1'b1, 8'h07);
        check("s5 rdwr level", 32'(level), 32'h2);
        check("s5 rdwr const", 32'(r_data), 32'h0706);
        for (int i = 0; i < 6; i++) step("s5 fill", 1'b1, 1'b0, 8'(8'h10 + i));
        step("s5 full rdwr", 1'b1, 1'b1, 8'hAA);
        check("s5 full level", 32'(level), 32'h6);

        // 6: repeated fill/drain across pointer wrap, then reset mid-fill
        for (int rep = 0; rep < 2; rep++) begin
            while (q.size() >= 2) step("s6 drain", 1'b0, 1'b1, 8'h00);
            while (q.size() < DEPTH) step("s6 fill", 1'b1, 1'b0, 8'($urandom_range(0, 255)));
            while (q.size() >= 2) step("s6 drain2", 1'b0, 1'b1, 8'h00);
        end
        while (q.size() < 5) step("s6 to5", 1'b1, 1'b0, 8'($urandom_range(0, 255)));
        check("s6 level5", 32'(level), 32'h5);
        do_reset("s6 reset", 1'b1, 1'b1);
        check("s6 reset level", 32'(level), 32'h0);
        check("s6 reset empty", 32'(empty), 32'h1);
        step("s6 after w", 1'b1, 1'b0, 8'h3C);
        step("s6 after w2", 1'b1, 1'b0, 8'hC3);
        check("s6 after const", 32'(r_data), 32'hC33C);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
